// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: register file, control, beq, hazards, ID/EX register.
// Define WB_BYPASS_EN for write-through register reads (otherwise a WB-match stall is used).
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] pc4,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [31:0] branch_target,
    output logic        branch_sel,
    output logic        stall,
    output logic [31:0] ex_pc4,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_dst,
    output logic        ex_alu_src,
    output logic        ex_mem_to_reg,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [1:0]  ex_alu_op
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
    } hist_t;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        reg_dst;
        logic        alu_src;
        logic        mem_to_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  alu_op;
    } id_ex_t;

    logic [31:0] regs [32];
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    logic        known;
    logic        is_beq;
    logic        reg_dst;
    logic        alu_src;
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  alu_op;

    hist_t       issue_rec;
    hist_t       hist_ex;
    hist_t       hist_mem;
    logic        ex_load;
    logic        squash;
    logic        load_use;
    logic        branch_hazard;
    logic        wb_hazard;
    logic        hazard;
    logic        bubble;
    id_ex_t      id_ex;
    id_ex_t      id_ex_next;

    assign opcode        = instruction[31:26];
    assign rs            = instruction[25:21];
    assign rt            = instruction[20:16];
    assign rd            = instruction[15:11];
    assign imm           = {{16{instruction[15]}}, instruction[15:0]};
    assign branch_target = pc4 + {imm[29:0], 2'b00};

    always_comb begin
        known      = 1'b0;
        is_beq     = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_op     = 2'b00;
        case (opcode)
            OP_RTYPE: begin
                known     = 1'b1;
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                alu_op    = 2'b10;
            end
            OP_LW: begin
                known      = 1'b1;
                alu_src    = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                mem_read   = 1'b1;
            end
            OP_SW: begin
                known     = 1'b1;
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OP_BEQ: begin
                known  = 1'b1;
                is_beq = 1'b1;
                alu_op = 2'b01;
            end
            OP_ADDI: begin
                known     = 1'b1;
                alu_src   = 1'b1;
                reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        issue_rec = '0;
        if (opcode == OP_RTYPE)
            issue_rec.dest = rd;
        else if (reg_write)
            issue_rec.dest = rt;
        issue_rec.valid = reg_write && (issue_rec.dest != 5'd0);
    end

    always_comb begin
        rs_data = regs[rs];
        rt_data = regs[rt];
`ifdef WB_BYPASS_EN
        if (wb_we && wb_addr == rs && rs != 5'd0)
            rs_data = wb_data;
        if (wb_we && wb_addr == rt && rt != 5'd0)
            rt_data = wb_data;
`endif
    end

    function automatic logic src_hit(input hist_t h, input logic [4:0] a,
                                     input logic [4:0] b);
        return h.valid && ((a != 5'd0 && h.dest == a) ||
                           (b != 5'd0 && h.dest == b));
    endfunction

`ifdef WB_BYPASS_EN
    assign wb_hazard = 1'b0;
`else
    hist_t hist_wb;
    assign wb_hazard = src_hit(hist_wb, rs, rt);
`endif

    assign load_use      = ex_load && src_hit(hist_ex, rs, rt);
    assign branch_hazard = is_beq &&
                           (src_hit(hist_ex, rs, rt) || src_hit(hist_mem, rs, rt));
    assign hazard        = load_use || branch_hazard || wb_hazard;

    // Squash wins: a wrong-path instruction raises neither stall nor branch.
    assign stall      = !reset && !squash && hazard;
    assign branch_sel = !reset && !squash && !hazard && is_beq &&
                        (rs_data == rt_data);
    assign bubble     = squash || hazard || !known;

    always_comb begin
        id_ex_next = '0;
        if (!bubble) begin
            id_ex_next.pc4        = pc4;
            id_ex_next.rs_data    = rs_data;
            id_ex_next.rt_data    = rt_data;
            id_ex_next.imm        = imm;
            id_ex_next.rs         = rs;
            id_ex_next.rt         = rt;
            id_ex_next.rd         = rd;
            id_ex_next.reg_dst    = reg_dst;
            id_ex_next.alu_src    = alu_src;
            id_ex_next.mem_to_reg = mem_to_reg;
            id_ex_next.reg_write  = reg_write;
            id_ex_next.mem_read   = mem_read;
            id_ex_next.mem_write  = mem_write;
            id_ex_next.alu_op     = alu_op;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (wb_we && wb_addr != 5'd0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex    <= '0;
            hist_ex  <= '0;
            hist_mem <= '0;
            ex_load  <= 1'b0;
            squash   <= 1'b0;
`ifndef WB_BYPASS_EN
            hist_wb  <= '0;
`endif
        end else begin
            id_ex    <= id_ex_next;
            hist_ex  <= bubble ? '0 : issue_rec;
            hist_mem <= hist_ex;
            ex_load  <= !bubble && mem_read;
            squash   <= branch_sel;
`ifndef WB_BYPASS_EN
            hist_wb  <= hist_mem;
`endif
        end
    end

    assign ex_pc4        = id_ex.pc4;
    assign ex_rs_data    = id_ex.rs_data;
    assign ex_rt_data    = id_ex.rt_data;
    assign ex_imm        = id_ex.imm;
    assign ex_rs         = id_ex.rs;
    assign ex_rt         = id_ex.rt;
    assign ex_rd         = id_ex.rd;
    assign ex_reg_dst    = id_ex.reg_dst;
    assign ex_alu_src    = id_ex.alu_src;
    assign ex_mem_to_reg = id_ex.mem_to_reg;
    assign ex_reg_write  = id_ex.reg_write;
    assign ex_mem_read   = id_ex.mem_read;
    assign ex_mem_write  = id_ex.mem_write;
    assign ex_alu_op     = id_ex.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus random traffic against a
// pipeline-occupancy reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] pc4;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] branch_target;
    logic        branch_sel;
    logic        stall;
    logic [31:0] ex_pc4;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic        ex_reg_dst;
    logic        ex_alu_src;
    logic        ex_mem_to_reg;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_alu_op;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk           (clk),
        .reset         (reset),
        .instruction   (instruction),
        .pc4           (pc4),
        .wb_we         (wb_we),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .branch_target (branch_target),
        .branch_sel    (branch_sel),
        .stall         (stall),
        .ex_pc4        (ex_pc4),
        .ex_rs_data    (ex_rs_data),
        .ex_rt_data    (ex_rt_data),
        .ex_imm        (ex_imm),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .ex_rd         (ex_rd),
        .ex_reg_dst    (ex_reg_dst),
        .ex_alu_src    (ex_alu_src),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_alu_op     (ex_alu_op)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

`ifdef WB_BYPASS_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 3;
`endif
    localparam logic [31:0] NOP = 32'hFC00_0000;

    // Model: register values plus the destinations of the last DEPTH issue slots.
    typedef struct {
        bit       wr;
        bit [4:0] dst;
        bit       ld;
    } rec_t;

    logic [31:0] m_reg [32];
    rec_t        m_hist [$];
    bit          m_squash;

    // {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, alu_op}
    function automatic logic [7:0] ctrl_of(input logic [5:0] op);
        case (op)
            6'h00:   return 8'b1001_0010;
            6'h23:   return 8'b0111_1000;
            6'h2B:   return 8'b0100_0100;
            6'h04:   return 8'b0000_0001;
            6'h08:   return 8'b0101_0000;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
`ifdef WB_BYPASS_EN
        if (wb_we && a != 5'd0 && wb_addr == a)
            return wb_data;
`endif
        return m_reg[a];
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] d, input logic [4:0] s,
                                          input logic [4:0] t);
        return {6'h00, s, t, d, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [6];
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B;
        ops[3] = 6'h04; ops[4] = 6'h08; ops[5] = 6'h3F;
        return {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                11'($urandom)};
    endfunction

    task automatic cycle(input logic [31:0] ins, input logic [31:0] p4,
                         input bit rst, input bit we, input logic [4:0] wa,
                         input logic [31:0] wd, output bit m_stall,
                         output bit d_stall, output bit d_bsel);
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [31:0] imm, a, b;
        logic [7:0]  ctrl;
        bit          stl, br, issue;
        rec_t        nr;
        @(negedge clk);
        reset = rst; instruction = ins; pc4 = p4;
        wb_we = we; wb_addr = wa; wb_data = wd;
        #1;
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
        imm = {{16{ins[15]}}, ins[15:0]};
        ctrl = ctrl_of(op);
        a = m_read(rs);
        b = m_read(rt);
        stl = 0;
        // slot 0 = EX, 1 = MEM, 2 = WB (only tracked without bypass)
        if (!rst && !m_squash)
            foreach (m_hist[i])
                if (m_hist[i].wr && ((rs != 0 && m_hist[i].dst == rs) ||
                                     (rt != 0 && m_hist[i].dst == rt)))
                    if ((i == 0 && m_hist[i].ld) || (i <= 1 && op == 6'h04) || i == 2)
                        stl = 1;
        br = !rst && !m_squash && !stl && op == 6'h04 && a == b;
        check("stall", stall, stl);
        check("branch_sel", branch_sel, br);
        check("branch_target", branch_target, p4 + (imm << 2));
        d_stall = stall;
        d_bsel = branch_sel;
        m_stall = stl;
        issue = !rst && !m_squash && !stl && ctrl != 8'h00;
        nr.dst = (op == 6'h00) ? rd : (op == 6'h23 || op == 6'h08) ? rt : 5'd0;
        if (!issue) nr.dst = 5'd0;
        nr.wr = nr.dst != 5'd0;
        nr.ld = issue && op == 6'h23;
        @(posedge clk);
        #1;
        check("ex_ctrl", {ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write,
                          ex_mem_read, ex_mem_write, ex_alu_op}, issue ? ctrl : 8'h00);
        check("ex_pc4", ex_pc4, issue ? p4 : 32'd0);
        check("ex_rs_data", ex_rs_data, issue ? a : 32'd0);
        check("ex_rt_data", ex_rt_data, issue ? b : 32'd0);
        check("ex_imm", ex_imm, issue ? imm : 32'd0);
        check("ex_regs", {ex_rs, ex_rt, ex_rd}, issue ? {rs, rt, rd} : 15'd0);
        if (rst) begin
            foreach (m_reg[i]) m_reg[i] = '0;
            m_hist = {};
            for (int i = 0; i < DEPTH; i++) m_hist.push_back('{0, 0, 0});
            m_squash = 0;
        end else begin
            if (we && wa != 0) m_reg[wa] = wd;
            m_hist.push_front(nr);
            void'(m_hist.pop_back());
            m_squash = br;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bit          ms, ds, db, rst, we;
        int          n;
        logic [31:0] cur, p, wd;
        logic [4:0]  wa;
        reset = 1; instruction = NOP; pc4 = 0;
        wb_we = 0; wb_addr = 0; wb_data = 0;
        m_squash = 0;

        cycle(NOP, 32'h0, 1, 0, 0, 0, ms, ds, db);
        cycle(NOP, 32'h4, 0, 1, 5'd1, 32'd5, ms, ds, db);
        cycle(NOP, 32'h8, 0, 1, 5'd2, 32'd7, ms, ds, db);
        cycle(rtype(3, 1, 2), 32'hC, 0, 0, 0, 0, ms, ds, db);
        check("add_rs_data", ex_rs_data, 32'd5);
        check("add_rt_data", ex_rt_data, 32'd7);
        check("add_rd", ex_rd, 32'd3);

        cycle(itype(6'h23, 1, 4, 16'd0), 32'h10, 0, 0, 0, 0, ms, ds, db);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(rtype(5, 4, 4), 32'h14, 0, 0, 0, 0, ms, ds, db);
            if (ds) n++;
            if (!ms) break;
        end
        check("lu_stall_cycles", n, 1);
        check("lu_issue_rd", ex_rd, 32'd5);

        cycle(itype(6'h04, 1, 1, 16'd3), 32'h10, 0, 0, 0, 0, ms, ds, db);
        check("beq_taken", db, 1);
        check("beq_no_stall", ds, 0);
        check("beq_target", branch_target, 32'h1C);
        cycle(itype(6'h08, 0, 9, 16'd1), 32'h14, 0, 0, 0, 0, ms, ds, db);
        check("squash_bubble", ex_reg_write, 0);
        check("squash_no_stall", ds, 0);

        cycle(itype(6'h08, 0, 6, 16'd1), 32'h20, 0, 0, 0, 0, ms, ds, db);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(itype(6'h04, 6, 0, 16'd2), 32'h24, 0, k == 2, 5'd6, 32'd1,
                  ms, ds, db);
            if (ds) n++;
            if (!ms) break;
        end
        check("beq_alu_stall_cycles", n, DEPTH);
        check("beq_alu_not_taken", db, 0);

        cycle(itype(6'h08, 0, 7, 16'h55), 32'h30, 0, 0, 0, 0, ms, ds, db);
        cycle(NOP, 32'h34, 0, 0, 0, 0, ms, ds, db);
        cycle(NOP, 32'h38, 0, 0, 0, 0, ms, ds, db);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(rtype(8, 7, 0), 32'h3C, 0, k == 0, 5'd7, 32'h55, ms, ds, db);
            if (ds) n++;
            if (!ms) break;
        end
        check("wb_same_stall_cycles", n, DEPTH - 2);
        check("wb_same_rs_data", ex_rs_data, 32'h55);

        cycle(itype(6'h23, 1, 4, 16'd0), 32'h40, 0, 0, 0, 0, ms, ds, db);
        cycle(rtype(5, 4, 4), 32'h44, 0, 0, 0, 0, ms, ds, db);
        check("rst_pre_stall", ds, 1);
        cycle(rtype(5, 4, 4), 32'h44, 1, 0, 0, 0, ms, ds, db);
        check("rst_stall_low", ds, 0);
        check("rst_ex_rd", ex_rd, 0);
        check("rst_ex_pc4", ex_pc4, 0);
        cycle(rtype(5, 4, 4), 32'h44, 0, 0, 0, 0, ms, ds, db);
        check("post_rst_stall", ds, 0);
        cycle(NOP, 32'h48, 0, 1, 5'd0, 32'hDEAD, ms, ds, db);
        cycle(rtype(10, 0, 0), 32'h4C, 0, 0, 0, 0, ms, ds, db);
        check("r0_zero", ex_rs_data, 0);

        cur = rand_instr();
        p = 32'h100;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            we = ($urandom_range(0, 1) == 1);
            wa = 5'($urandom_range(0, 7));
            wd = 32'($urandom_range(0, 3));
            cycle(cur, p, rst, we, wa, wd, ms, ds, db);
            if (!ms || rst) begin
                cur = rand_instr();
                p = p + 4;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the five-stage MIPS pipeline, directly downstream of the fetch stage's IF/ID register (`instruction`, `pc4`). It contains the 32×32 register file, main control decode, sign extension, ID-resolved `beq`, and load-use/branch hazard detection. It also holds the ID/EX pipeline register. It returns `branch_target`/`branch_sel` to the fetch PC mux and `stall` to the upstream hold logic.

## Interface
- No parameters. Datapath is 32 bits; register file is 32 entries; r0 is hardwired to zero.
- `clk` in 1: rising-edge clock.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `instruction` in 32: IF/ID instruction.
- `pc4` in 32: IF/ID PC+4.
- `wb_we` in 1: writeback enable.
- `wb_addr` in 5: writeback register.
- `wb_data` in 32: writeback data.
- `branch_target` out 32: `pc4 + (sext(imm)<<2)`, combinational; drives fetch `beq`.
- `branch_sel` out 1: taken branch, combinational; drives fetch `sel`.
- `stall` out 1: combinational; upstream must hold PC and IF/ID for that cycle.
- `ex_pc4` out 32: registered ID/EX PC+4.
- `ex_rs_data` out 32: registered.
- `ex_rt_data` out 32: registered.
- `ex_imm` out 32: registered.
- `ex_rs` out 5: registered.
- `ex_rt` out 5: registered.
- `ex_rd` out 5: registered.
- `ex_reg_dst`, `ex_alu_src`, `ex_mem_to_reg`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write` out 1 each: registered control bits.
- `ex_alu_op` out 2: registered.

## Operation
- Decode by opcode:
  - R-type 0x00: reg_dst=1, reg_write=1, alu_op=10.
  - lw 0x23: alu_src, mem_to_reg, reg_write, mem_read; alu_op=00.
  - sw 0x2B: alu_src, mem_write; alu_op=00.
  - beq 0x04: alu_op=01, no writes.
  - addi 0x08: alu_src, reg_write; alu_op=00.
  - Any other opcode is a bubble (all controls 0).
- Destination register: rd for R-type, rt for lw/addi, none otherwise. r0 never counts as a destination.
- Register file: writes on the rising edge when `wb_we` is high and `wb_addr` is nonzero. Reads are combinational.
- Two-entry issue history (`EX`, `MEM`), each holding {valid dest, dest, is_load}. It shifts every cycle and a bubble enters `EX` whenever a bubble is issued.
- Load-use stall: `EX` is a load and its dest equals a nonzero rs or rt of the current instruction.
- Branch stall: the current instruction is beq and a nonzero rs or rt equals the dest of `EX` or `MEM`.
- On stall: a bubble is written to ID/EX, `branch_sel`=0, and IF/ID must not advance.
- Taken branch: beq, not stalled, not squashed, and rs_data == rt_data. Sets `branch_sel`=1 and sets the squash flag for one cycle.
- Squash flag set: the next IF/ID instruction (wrong path) is issued as a bubble and may raise neither stall nor branch. The flag then clears. Squash has priority over stall.
- Bubble: all ID/EX control bits are 0. Data and address fields are don't-care but are driven to 0.

## Timing
- ID/EX latency is 1 cycle; the decoded instruction appears on `ex_*` after the next rising edge.
- `branch_sel`, `branch_target` and `stall` are valid in the same cycle. The PC loads the target at the next edge, and the wrong-path fetch is squashed the cycle after.
- Stall durations:
  - Load-use: 1 cycle.
  - beq behind ALU producer: 2 cycles. `EX` match stalls, then `MEM` match stalls.
  - beq behind lw: 2 cycles.
- Reset (any cycle, including mid-stall or squash):
  - All `ex_*` = 0.
  - History and squash flag cleared.
  - All 32 registers = 0.
  - `stall`=0 and `branch_sel`=0 while `reset` is high.
- Simultaneous WB write and ID read of the same register: see Configuration.

## Configuration
- `WB_BYPASS_EN` defined: register-file read returns `wb_data` when `wb_we`, `wb_addr`==src and src≠0 (write-through). The history depth is 2.
- Undefined: reads return the pre-write value. The history is extended with a `WB` entry. Any instruction (not only beq) stalls while a nonzero source matches the `WB` dest, for 1 cycle.

## Test plan
- Reset, then `add $3,$1,$2` with r1=5, r2=7 preloaded via WB:
  - Next cycle: `ex_rs_data`=5, `ex_rt_data`=7, `ex_rd`=3, reg_dst=1, reg_write=1, alu_op=10.
- `lw $4,0($1)` followed by `add $5,$4,$4`:
  - `stall`=1 for exactly one cycle.
  - Bubble on `ex_*`.
  - add issues the following cycle.
- `beq $1,$1,+3` at pc4=0x10:
  - Same cycle: `branch_sel`=1, `branch_target`=0x1C.
  - Next IF/ID instruction issues as a bubble.
  - No stall.
- `addi $6,$0,1` then `beq $6,$0,x`: `stall` high for 2 cycles, then beq resolves with `branch_sel`=0.
- Same-cycle WB of r7=0x55 while decoding `add $8,$7,$0`:
  - With `WB_BYPASS_EN`: `ex_rs_data`=0x55, no stall.
  - Without: 1-cycle stall, then 0x55.
- Assert `reset` during a load-use stall: next cycle all `ex_*`=0 and `stall`=0. A subsequent WB to r0 leaves r0 reading 0.
